// File: rtl/mips_pkg.sv
// Shared types for the MIPS-style datapath blocks.
// Holds the HI/LO unit opcodes, its FSM states and the data width.
package mips_pkg;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;
endpackage

// File: rtl/md_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add on {hi,lo}. Divide: restoring shift-subtract, quotient bits shift into lo.
module md_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shl  = {hi_i, lo_i[WIDTH-1]};
    ge   = (shl >= {1'b0, opnd_i});
    // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
    diff = shl[WIDTH-1:0] - opnd_i;
    if (div_i) begin
      hi_o = ge ? diff : shl[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Operates on magnitudes during RUN and applies sign correction once in FIX.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t        state_q, state_d;
  md_op_t           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d, bz_q, bz_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   step_hi, step_lo, mag_a, mag_b, q_neg, r_neg;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic               a_neg, b_neg, accept;

  md_step #(.WIDTH(WIDTH)) u_step (
    .hi_i  (acc_q),
    .lo_i  (wrk_q),
    .opnd_i(opnd_q),
    .div_i (op_q[1]),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  assign a_neg    = Op[0] & OperandA[WIDTH-1];
  assign b_neg    = Op[0] & OperandB[WIDTH-1];
  assign mag_a    = a_neg ? -OperandA : OperandA;
  assign mag_b    = b_neg ? -OperandB : OperandB;
  assign accept   = Start && (state_q == MD_IDLE || state_q == MD_DONE);
  assign prod     = {acc_q, wrk_q};
  assign prod_neg = -prod;
  assign q_neg    = -wrk_q;
  assign r_neg    = -acc_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    dbz_d   = dbz_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_RUN: begin
        acc_d = step_hi;
        wrk_d = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_DONE;
        dbz_d   = op_q[1] & bz_q;
        if (!op_q[1]) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : prod;
        end else if (bz_q) begin
          // A zero divisor leaves |A| in the remainder; restoring its sign yields A as captured.
          lo_d = '1;
          hi_d = sa_q ? r_neg : acc_q;
        end else begin
          lo_d = (sa_q ^ sb_q) ? q_neg : wrk_q;
          hi_d = sa_q ? r_neg : acc_q;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = MD_RUN;
      op_d    = md_op_t'(Op);
      cnt_d   = CNT_W'(WIDTH);
      sa_d    = a_neg;
      sb_d    = b_neg;
      bz_d    = (OperandB == '0);
      acc_d   = '0;
      wrk_d   = Op[1] ? mag_a : mag_b;
      opnd_d  = Op[1] ? mag_b : mag_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MULTU;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      dbz_q   <= 1'b0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      dbz_q   <= dbz_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy      = (state_q == MD_RUN) || (state_q == MD_FIX);
  assign Done      = (state_q == MD_DONE);
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model plus timing model, checked every cycle,
// directed corner cases with literal expectations, and a randomized traffic phase.
module tb_mult_div_unit;
  logic        clk = 1'b0, rst_n = 1'b0, Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [15:0] A = '0, B = '0;
  logic        Busy, Done, DivByZero;
  logic [15:0] Hi, Lo;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .OperandA(A), .OperandB(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  // Result as {DivByZero, Hi, Lo}, straight from the instruction-set definition.
  function automatic logic [32:0] md_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, q, r;
    logic [31:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: begin p = {16'h0, a} * {16'h0, b}; return {1'b0, p}; end
      2'd1: begin q = sa * sb; return {1'b0, q[31:0]}; end
      2'd2: begin
        if (b == 16'h0) return {1'b1, a, 16'hFFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 16'h0) return {1'b1, a, 16'hFFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[15:0], q[15:0]};
      end
    endcase
  endfunction

  task automatic check_v(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Timing model: an accepted request at edge E completes at edge E+17; a new one may be taken from E+18.
  int          cyc = 0, E = 0;
  bit          act = 1'b0;
  logic [1:0]  mop = '0;
  logic [15:0] ma = '0, mb = '0, m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act   <= 1'b0;
      m_hi  <= '0;
      m_lo  <= '0;
      m_dbz <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (act && cyc == E + 17) {m_dbz, m_hi, m_lo} <= md_ref(mop, ma, mb);
      if (Start && (!act || cyc >= E + 18)) begin
        act <= 1'b1;
        E   <= cyc;
        mop <= Op;
        ma  <= A;
        mb  <= B;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    int  e;
    bit  eb, ed;
    if (chk_en && rst_n) begin
      e  = cyc - 1;
      eb = act && e >= E && e <= E + 16;
      ed = act && e == E + 17;
      total++;
      if ({Busy, Done, DivByZero, Hi, Lo} !== {eb, ed, m_dbz, m_hi, m_lo}) begin
        bad++;
        $display("FAIL cycle%0d: got busy=%b done=%b dbz=%b hi=%h lo=%h want busy=%b done=%b dbz=%b hi=%h lo=%h",
                 e, Busy, Done, DivByZero, Hi, Lo, eb, ed, m_dbz, m_hi, m_lo);
      end
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [32:0] exp, input string nm);
    int n;
    @(posedge clk); #1;
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; A = 16'($urandom); B = 16'($urandom);
    n = 1;
    while (!Done && n < 40) begin @(posedge clk); #1; n++; end
    check_v({nm, "_latency"}, 33'(n), 33'd18);
    check_v({nm, "_result"}, {DivByZero, Hi, Lo}, exp);
    @(posedge clk); #1;
    check_v({nm, "_done_width"}, 33'(Done), 33'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1 $display("watchdog armed");
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #12;
    check_v("rst_busy", 33'(Busy), 33'd0);
    check_v("rst_done", 33'(Done), 33'd0);
    check_v("rst_dbz", 33'(DivByZero), 33'd0);
    check_v("rst_hilo", {1'b0, Hi, Lo}, 33'd0);

    check_v("ref_multu", md_ref(2'd0, 16'hFFFF, 16'hFFFF), {1'b0, 32'hFFFE_0001});
    check_v("ref_mult", md_ref(2'd1, 16'hFFFD, 16'h0007), {1'b0, 32'hFFFF_FFEB});
    check_v("ref_div", md_ref(2'd3, 16'hFFF9, 16'h0002), {1'b0, 16'hFFFF, 16'hFFFD});
    check_v("ref_ovf", md_ref(2'd3, 16'h8000, 16'hFFFF), {1'b0, 16'h0000, 16'h8000});

    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_op(2'd0, 16'hFFFF, 16'hFFFF, {1'b0, 16'hFFFE, 16'h0001}, "multu_max");
    do_op(2'd1, 16'hFFFD, 16'h0007, {1'b0, 16'hFFFF, 16'hFFEB}, "mult_neg");
    do_op(2'd3, 16'hFFF9, 16'h0002, {1'b0, 16'hFFFF, 16'hFFFD}, "div_neg");
    do_op(2'd2, 16'd100, 16'd7, {1'b0, 16'd2, 16'd14}, "divu");
    do_op(2'd3, 16'h8000, 16'hFFFF, {1'b0, 16'h0000, 16'h8000}, "div_ovf");
    do_op(2'd2, 16'h0005, 16'h0000, {1'b1, 16'h0005, 16'hFFFF}, "divu_zero");
    do_op(2'd0, 16'd2, 16'd3, {1'b0, 16'd0, 16'd6}, "multu_after_dbz");
    do_op(2'd3, 16'hFFF9, 16'h0000, {1'b1, 16'hFFF9, 16'hFFFF}, "div_zero_neg");

    // Start while busy is dropped; Start in the Done cycle chains.
    @(posedge clk); #1;
    Start = 1'b1; Op = 2'd0; A = 16'd3; B = 16'd5;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Start = 1'b1; Op = 2'd2; A = 16'h00FF; B = 16'h0002;
    @(posedge clk); #1;
    Start = 1'b0;
    n = 0;
    while (!Done && n < 40) begin @(posedge clk); #1; n++; end
    check_v("busy_drop_result", {DivByZero, Hi, Lo}, {1'b0, 32'd15});
    Start = 1'b1; Op = 2'd1; A = 16'hFFFE; B = 16'h0004;
    @(posedge clk); #1;
    Start = 1'b0;
    n = 1;
    while (!Done && n < 40) begin @(posedge clk); #1; n++; end
    check_v("b2b_latency", 33'(n), 33'd18);
    check_v("b2b_result", {DivByZero, Hi, Lo}, {1'b0, 32'hFFFF_FFF8});

    // Reset in the 8th RUN cycle aborts the multiply.
    @(posedge clk); #1;
    Start = 1'b1; Op = 2'd0; A = 16'h1234; B = 16'h5678;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_v("abort_busy", 33'(Busy), 33'd0);
    check_v("abort_done", 33'(Done), 33'd0);
    check_v("abort_hilo", {1'b0, Hi, Lo}, 33'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin @(posedge clk); #1; if (Done) n++; end
    check_v("abort_no_done", 33'(n), 33'd0);

    repeat (3000) begin
      @(posedge clk); #1;
      Start = ($urandom_range(0, 3) == 0);
      Op    = 2'($urandom);
      A     = pick();
      B     = pick();
    end
    Start = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
